// File: rtl/uart_rx_os_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART receiver.
//   rx_state_t  receiver FSM state
//   OS_RATIO    oversampling ratio (ticks per bit)
//   MID_LO/HI   first/last os_cnt of the majority-vote window
//   tick_div()  clocks per oversample tick, integer floor
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_t;

    localparam int OS_RATIO = 16;
    localparam int MID_LO   = 7;
    localparam int MID_HI   = 9;

    function automatic int tick_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OS_RATIO);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-word stream plus status from the UART receiver.
//   master (receiver): drives rx_data, rx_valid, framing_error, break_det,
//                      overrun, rx_busy; samples rx_ready
//   slave  (consumer): the reverse
interface uart_rx_os_if #(
    parameter int DBITS = 8
);
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             framing_error;
    logic             break_det;
    logic             overrun;
    logic             rx_busy;

    modport master (
        output rx_data, rx_valid, framing_error, break_det, overrun, rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, framing_error, break_det, overrun, rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os_tick.sv
// uart_os_tick: free-running divider, one-clock tick every DIV clocks.
//   clk, rst_n  system clock, async active-low reset
//   tick        1-clk strobe, period DIV clocks
module uart_os_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with glitch filter, 3-sample
// majority vote at mid-bit, framing-error / break detection and a one-word
// holding register on a valid/ready stream.
//   clk, rst_n    system clock, async active-low reset
//   rx_serial_in  asynchronous serial line, idle high
//   rx            uart_rx_os_if.master: rx_data/rx_valid/rx_ready,
//                 framing_error, break_det, overrun pulse, rx_busy
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DBITS       = 8,
    parameter int STOP_BIT    = 1,
    parameter int OS          = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_serial_in,
    uart_rx_os_if.master rx
);
    localparam int TICK_DIV = tick_div(CLK_FREQ_HZ, BAUD);

    if (OS != OS_RATIO) begin : g_bad_os
        $error("uart_rx_os: OS must be 16");
    end
    if (DBITS < 5 || DBITS > 9) begin : g_bad_dbits
        $error("uart_rx_os: DBITS must be 5..9");
    end
    if (STOP_BIT < 1 || STOP_BIT > 2) begin : g_bad_stop
        $error("uart_rx_os: STOP_BIT must be 1 or 2");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("uart_rx_os: clock too slow for BAUD*16");
    end

    logic tick;

    uart_os_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // 2-FF synchronizer, reset to the idle level so reset release is not a start edge
    logic sync_q1, rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync_q1 <= rx_serial_in;
            rxs     <= sync_q1;
        end
    end

    rx_state_t        state;
    logic [3:0]       os_cnt;
    logic [3:0]       bit_idx;
    logic             stop_idx;
    logic             samp7, samp8;
    logic [DBITS-1:0] shreg;
    logic             fe_acc;
    logic             stop0_low;
    logic             busy;

    logic maj, decide, last_stop, complete;
    logic first_stop_low, frame_fe, frame_brk;

    // samples at os_cnt 7 and 8 are stored; the one at 9 is the live rxs
    assign maj            = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
    assign decide         = tick && (os_cnt == 4'(MID_HI));
    assign last_stop      = (stop_idx == 1'(STOP_BIT - 1));
    assign complete       = decide && (state == STOP) && last_stop;
    assign first_stop_low = (stop_idx == 1'b0) ? ~maj : stop0_low;
    assign frame_fe       = fe_acc | ~maj;
    assign frame_brk      = (shreg == '0) && first_stop_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            samp7     <= 1'b1;
            samp8     <= 1'b1;
            shreg     <= '0;
            fe_acc    <= 1'b0;
            stop0_low <= 1'b0;
            busy      <= 1'b0;
        end else if (tick) begin
            if (state == START || state == DATA || state == STOP) begin
                os_cnt <= os_cnt + 4'd1;   // 15 -> 0 wrap marks the next bit
                if (os_cnt == 4'(MID_LO))     samp7 <= rxs;
                if (os_cnt == 4'(MID_LO + 1)) samp8 <= rxs;
            end
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        os_cnt <= '0;
                        state  <= START;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (maj) begin          // start bit didn't hold: glitch
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg <= {maj, shreg[DBITS-1:1]};
                        if (bit_idx == 4'(DBITS - 1)) begin
                            state    <= STOP;
                            stop_idx <= 1'b0;
                            fe_acc   <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (decide) begin
                        fe_acc <= fe_acc | ~maj;
                        if (stop_idx == 1'b0) stop0_low <= ~maj;
                        if (last_stop) begin
                            // finishing at mid-stop leaves half a bit to
                            // catch the next start edge on back-to-back frames
                            busy  <= 1'b0;
                            state <= frame_brk ? BRK : IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                BRK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // output holding register; rx_ready only feeds flops
    logic [DBITS-1:0] data_q;
    logic             valid_q, fe_q, brk_q, ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (complete) begin
                if (!valid_q || rx.rx_ready) begin
                    data_q  <= shreg;
                    fe_q    <= frame_fe;
                    brk_q   <= frame_brk;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;          // old word kept, new one dropped
                end
            end else if (valid_q && rx.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data       = data_q;
    assign rx.rx_valid      = valid_q;
    assign rx.framing_error = fe_q;
    assign rx.break_det     = brk_q;
    assign rx.overrun       = ovr_q;
    assign rx.rx_busy       = busy;

endmodule
